systolic_array: RTL and testbench



---
 rtl/mac_pkg.sv | 17 +
 rtl/tpumac.sv | 62 ++++++
 rtl/systolic_array.sv | 83 ++++++++
 tb/tb_systolic_array.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants for the systolic MAC datapath.
//   DEF_BITS_AB : default width of the signed A/B operands
//   DEF_BITS_C  : default width of the signed accumulators
//   DEF_DIM     : default array dimension (rows = columns)
//   row_sel_w() : width of the row-select bus for a given dimension
package mac_pkg;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_DIM     = 8;

  // A 1x1 array still needs a 1-bit select so the port never collapses to zero width.
  function automatic int row_sel_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/tpumac.sv
// tpumac: one output-stationary multiply-accumulate processing element.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : forward Ain/Bin and accumulate Ain*Bin into C
//   WrEn            : load C from Cin (wins over accumulate for C only)
//   Ain, Bin        : signed operands from the left / top neighbour
//   Cin             : accumulator load value
//   Aout, Bout      : registered operands toward the right / lower neighbour
//   Cout            : current accumulator value
module tpumac
  import mac_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic        [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic        [BITS_C-1:0]  Cout
);

  logic signed [2*BITS_AB-1:0] w_prod;
  logic signed [BITS_C-1:0]    w_prod_c;
  logic signed [BITS_AB-1:0]   r_a;
  logic signed [BITS_AB-1:0]   r_b;
  logic        [BITS_C-1:0]    r_c;

  assign w_prod = Ain * Bin;

  // Size cast of a signed value sign-extends when widening and keeps the low
  // bits when narrowing; the accumulate then wraps modulo 2^BITS_C.
  assign w_prod_c = BITS_C'(w_prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else begin
      if (en) begin
        r_a <= Ain;
        r_b <= Bin;
      end
      if (WrEn) begin
        r_c <= Cin;
      end else if (en) begin
        r_c <= r_c + w_prod_c;
      end
    end
  end

  assign Aout = r_a;
  assign Bout = r_b;
  assign Cout = r_c;

endmodule

// File: rtl/systolic_array.sv
// systolic_array: DIM x DIM output-stationary grid of tpumac PEs.
// A enters on the left edge (slice r -> row r), B on the top edge
// (slice c -> column c); both must arrive pre-skewed by the upstream FIFOs.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears every PE)
//   en       : advance all PEs one step (shift A right, B down, accumulate)
//   WrEn     : load accumulators of row Crow from Cin
//   A, B     : flattened edge operand buses
//   Cin      : flattened write data, slice c -> column c of row Crow
//   Crow     : row select shared by write and read
//   Cout     : combinational read of row Crow, slice c = column c
module systolic_array
  import mac_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C,
  parameter int DIM     = DEF_DIM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        WrEn,
  input  logic [DIM*BITS_AB-1:0]      A,
  input  logic [DIM*BITS_AB-1:0]      B,
  input  logic [DIM*BITS_C-1:0]       Cin,
  input  logic [row_sel_w(DIM)-1:0]   Crow,
  output logic [DIM*BITS_C-1:0]       Cout
);

  localparam int ROW_W = row_sel_w(DIM);

  // w_a[r][c] is Ain of PE(r,c); column DIM is the discarded right edge.
  // w_b[r][c] is Bin of PE(r,c); row DIM is the discarded bottom edge.
  logic signed [BITS_AB-1:0] w_a [DIM][DIM+1];
  logic signed [BITS_AB-1:0] w_b [DIM+1][DIM];
  logic        [BITS_C-1:0]  w_c [DIM][DIM];
  logic        [DIM-1:0]     w_wr_row;
  logic        [DIM-1:0]     w_unused_a_edge;
  logic        [DIM-1:0]     w_unused_b_edge;

  for (genvar c = 0; c < DIM; c++) begin : g_top_edge
    assign w_b[0][c]          = B[c*BITS_AB +: BITS_AB];
    assign w_unused_b_edge[c] = ^w_b[DIM][c];
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    assign w_a[r][0]          = A[r*BITS_AB +: BITS_AB];
    assign w_unused_a_edge[r] = ^w_a[r][DIM];
    // Out-of-range Crow matches no row, so such writes are dropped.
    assign w_wr_row[r]        = WrEn && (Crow == ROW_W'(r));

    for (genvar c = 0; c < DIM; c++) begin : g_col
      tpumac #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .WrEn (w_wr_row[r]),
        .Ain  (w_a[r][c]),
        .Bin  (w_b[r][c]),
        .Cin  (Cin[c*BITS_C +: BITS_C]),
        .Aout (w_a[r][c+1]),
        .Bout (w_b[r+1][c]),
        .Cout (w_c[r][c])
      );
    end
  end

  // Row read mux; defaults to 0 so an out-of-range Crow reads zero.
  always_comb begin
    Cout = '0;
    for (int r = 0; r < DIM; r++) begin
      if (Crow == ROW_W'(r)) begin
        for (int c = 0; c < DIM; c++) begin
          Cout[c*BITS_C +: BITS_C] = w_c[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: randomized and directed checks of systolic_array against
// a matrix-product reference model (C = base + A x B, modulo 2^BITS_C).
module tb_systolic_array;

  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;
  localparam int K       = 8;
  localparam int STEPS   = K + 2*DIM - 2;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    WrEn;
  logic [DIM*BITS_AB-1:0]  A;
  logic [DIM*BITS_AB-1:0]  B;
  logic [DIM*BITS_C-1:0]   Cin;
  logic [2:0]              Crow;
  logic [DIM*BITS_C-1:0]   Cout;

  int checks = 0;
  int errors = 0;

  // Operand matrices: am is DIM x K, bm is K x DIM; base_c is the preload.
  logic signed [BITS_AB-1:0] am [DIM][K];
  logic signed [BITS_AB-1:0] bm [K][DIM];
  int                        base_c [DIM][DIM];
  logic [DIM*BITS_C-1:0]     exp_q [$];

  systolic_array #(
    .BITS_AB (BITS_AB),
    .BITS_C  (BITS_C),
    .DIM     (DIM)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .WrEn (WrEn),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Crow (Crow),
    .Cout (Cout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; WrEn = 1'b0; A = '0; B = '0; Cin = '0; Crow = '0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Skewed edge data at step t: row r sees am[r][t-r], column c sees bm[t-c][c].
  task automatic set_edges(input int t);
    for (int r = 0; r < DIM; r++) begin
      A[r*BITS_AB +: BITS_AB] = (t - r >= 0 && t - r < K) ? am[r][t-r] : '0;
    end
    for (int c = 0; c < DIM; c++) begin
      B[c*BITS_AB +: BITS_AB] = (t - c >= 0 && t - c < K) ? bm[t-c][c] : '0;
    end
  endtask

  // Streams steps t0..STEPS-1; before step stall_at, en drops for stall_len
  // cycles with that step's edge data already held on A/B.
  task automatic run_stream(input int t0, input int stall_at, input int stall_len);
    for (int t = t0; t < STEPS; t++) begin
      set_edges(t);
      if (t == stall_at) begin
        en = 1'b0;
        repeat (stall_len) tick();
      end
      en = 1'b1;
      tick();
    end
    en = 1'b0; A = '0; B = '0;
  endtask

  task automatic write_row(input int row, input logic [DIM*BITS_C-1:0] data);
    WrEn = 1'b1; Crow = 3'(row); Cin = data;
    tick();
    WrEn = 1'b0; Cin = '0;
  endtask

  task automatic clear_base();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) base_c[r][c] = 0;
  endtask

  task automatic rand_mats();
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < K; k++) begin
        am[i][k] = BITS_AB'($urandom_range(0, 255));
        bm[k][i] = BITS_AB'($urandom_range(0, 255));
      end
  endtask

  // ---------------- scoreboard model ----------------
  // Pushes one expected row per entry: base + dot(am row, bm column), wrapped.
  task automatic model_push();
    logic [DIM*BITS_C-1:0] row_v;
    int sum;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        sum = base_c[r][c];
        for (int k = 0; k < K; k++) sum += int'(am[r][k]) * int'(bm[k][c]);
        row_v[c*BITS_C +: BITS_C] = sum[BITS_C-1:0];
      end
      exp_q.push_back(row_v);
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < K; k++) begin
        am[i][k] = (i == k) ? 8'sd1 : 8'sd0;
        bm[k][i] = BITS_AB'(k*8 + i);
      end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DIM*BITS_C-1:0] exp;
    // rst must win over a simultaneous write and accumulate.
    set_identity();
    run_stream(0, -1, 0);
    rst = 1'b1; en = 1'b1; WrEn = 1'b1; Crow = 3'd0; Cin = {DIM{16'h5a5a}};
    A = {DIM{8'h11}}; B = {DIM{8'h22}};
    tick();
    rst = 1'b0; en = 1'b0; WrEn = 1'b0; Cin = '0; A = '0; B = '0;
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r); #1;
      exp = '0;
      checks++;
      if (Cout !== exp) begin
        errors++;
        $display("FAIL reset row %0d: got %h expected %h", r, Cout, exp);
      end
    end
  endtask

  task automatic test_identity();
    logic [DIM*BITS_C-1:0] exp;
    do_reset();
    set_identity(); clear_base(); model_push();
    run_stream(0, -1, 0);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r); #1;
      exp = exp_q.pop_front();
      checks++;
      if (Cout !== exp) begin
        errors++;
        $display("FAIL identity row %0d: got %h expected %h", r, Cout, exp);
      end
    end
  endtask

  task automatic test_signed_wrap();
    logic [DIM*BITS_C-1:0] exp;
    do_reset();
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < K; k++) begin am[i][k] = -8'sd128; bm[k][i] = -8'sd128; end
    clear_base(); model_push();
    run_stream(0, -1, 0);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r); #1;
      exp = exp_q.pop_front();
      checks++;
      if (Cout !== exp) begin
        errors++;
        $display("FAIL wrap row %0d: got %h expected %h", r, Cout, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [DIM*BITS_C-1:0] exp;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      rand_mats(); clear_base(); model_push();
      run_stream(0, -1, 0);
      for (int r = 0; r < DIM; r++) begin
        Crow = 3'(r); #1;
        exp = exp_q.pop_front();
        checks++;
        if (Cout !== exp) begin
          errors++;
          $display("FAIL random%0d row %0d: got %h expected %h", it, r, Cout, exp);
        end
      end
    end
  endtask

  task automatic test_load_read();
    logic [DIM*BITS_C-1:0] wdat;
    logic [DIM*BITS_C-1:0] exp;
    do_reset();
    for (int c = 0; c < DIM; c++) wdat[c*BITS_C +: BITS_C] = 16'(16'h1111 * (c + 1));
    write_row(3, wdat);
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < DIM; r++) begin
        Crow = 3'(r); #1;
        exp = (r == 3) ? wdat : '0;
        checks++;
        if (Cout !== exp) begin
          errors++;
          $display("FAIL load pass%0d row %0d: got %h expected %h", pass, r, Cout, exp);
        end
      end
      // One enabled cycle with zero operands must leave everything unchanged.
      A = '0; B = '0; en = 1'b1;
      tick();
      en = 1'b0;
    end
  endtask

  task automatic test_write_with_en();
    logic [DIM*BITS_C-1:0] row1;
    logic [DIM*BITS_C-1:0] exp;
    int v;
    do_reset();
    write_row(0, {DIM{16'd5}});
    for (int c = 0; c < DIM; c++) row1[c*BITS_C +: BITS_C] = BITS_C'($urandom_range(0, 65535));
    write_row(1, row1);
    rand_mats();
    for (int k = 0; k < K; k++) bm[k][0] = (bm[k][0] == 0) ? 8'sd3 : bm[k][0];
    if (am[0][0] == 0) am[0][0] = 8'sd7;
    // First enabled edge also writes 7s into row 0.
    set_edges(0);
    en = 1'b1; WrEn = 1'b1; Crow = 3'd0; Cin = {DIM{16'd7}};
    tick();
    en = 1'b0; WrEn = 1'b0; Cin = '0;
    Crow = 3'd0; #1;
    exp = {DIM{16'd7}};
    checks++;
    if (Cout !== exp) begin
      errors++;
      $display("FAIL wr_en row0 after write: got %h expected %h", Cout, exp);
    end
    // Row 0 starts from 7; PE(0,0)'s k=0 term met the write and was dropped,
    // since PE(0,c) only sees term k at step k+c.
    clear_base();
    for (int c = 0; c < DIM; c++) begin
      base_c[0][c] = 7;
      v = row1[c*BITS_C +: BITS_C];
      base_c[1][c] = v;
    end
    base_c[0][0] = 7 - int'(am[0][0]) * int'(bm[0][0]);
    model_push();
    run_stream(1, -1, 0);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r); #1;
      exp = exp_q.pop_front();
      checks++;
      if (Cout !== exp) begin
        errors++;
        $display("FAIL wr_en row %0d: got %h expected %h", r, Cout, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [DIM*BITS_C-1:0] exp;
    do_reset();
    rand_mats(); clear_base(); model_push();
    run_stream(0, $urandom_range(3, STEPS - 3), 5);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r); #1;
      exp = exp_q.pop_front();
      checks++;
      if (Cout !== exp) begin
        errors++;
        $display("FAIL stall row %0d: got %h expected %h", r, Cout, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DIM*BITS_C-1:0] exp;
    do_reset();
    rand_mats();
    for (int t = 0; t < 10; t++) begin
      set_edges(t); en = 1'b1;
      tick();
    end
    en = 1'b0;
    do_reset();
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r); #1;
      exp = '0;
      checks++;
      if (Cout !== exp) begin
        errors++;
        $display("FAIL reset_mid row %0d: got %h expected %h", r, Cout, exp);
      end
    end
    set_identity(); clear_base(); model_push();
    run_stream(0, -1, 0);
    for (int r = 0; r < DIM; r++) begin
      Crow = 3'(r); #1;
      exp = exp_q.pop_front();
      checks++;
      if (Cout !== exp) begin
        errors++;
        $display("FAIL reset_mid rerun row %0d: got %h expected %h", r, Cout, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    do_reset();
    @(negedge clk);
    test_reset();
    test_identity();
    test_signed_wrap();
    test_random();
    test_load_read();
    test_write_with_en();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
